// File: rtl/bicubic_tap_filter_if.sv
// AXI4-Stream video link: payload plus end-of-line (tlast) and end-of-frame markers.
interface bicubic_tap_filter_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              eof;

  modport master (output tdata, tvalid, tlast, eof, input tready);
  modport slave  (input tdata, tvalid, tlast, eof, output tready);
endinterface

// File: rtl/bicubic_tap_filter.sv
// Keys cubic (a = -0.5) 4-tap interpolator over RGB888 tap beats; three-stage
// pipeline with full backpressure and SOF/EOL/EOF sidebands riding with each beat.
module bicubic_tap_filter #(
  parameter int COEF_FRAC   = 7,
  parameter int LINE_PHASES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  bicubic_tap_filter_if.slave  s_axis,
  bicubic_tap_filter_if.master m_axis,
  output logic                 m_axis_tuser,
  output logic                 o_len_err
);
  localparam logic [1:0]         LAST_PHASE = 2'(LINE_PHASES - 1);
  localparam logic signed [18:0] ROUND_HALF = 19'sd1 <<< (COEF_FRAC - 1);

  // 128 does not fit Q1.7 signed 8-bit, so coefficients carry one guard bit
  function automatic logic signed [8:0] coef(input logic [1:0] ph, input logic [1:0] k);
    logic signed [8:0] c;
    case ({ph, k})
      4'b00_01: c = 9'sd128;
      4'b01_00: c = -9'sd9;
      4'b01_01: c = 9'sd111;
      4'b01_10: c = 9'sd29;
      4'b01_11: c = -9'sd3;
      4'b10_00: c = -9'sd8;
      4'b10_01: c = 9'sd72;
      4'b10_10: c = 9'sd72;
      4'b10_11: c = -9'sd8;
      4'b11_00: c = -9'sd3;
      4'b11_01: c = 9'sd29;
      4'b11_10: c = 9'sd111;
      4'b11_11: c = -9'sd9;
      default:  c = 9'sd0;
    endcase
    return c;
  endfunction

  function automatic logic signed [16:0] prod(input logic [7:0] px, input logic signed [8:0] c);
    logic signed [17:0] full;
    full = 18'($signed({1'b0, px})) * 18'(c);
    return full[16:0];
  endfunction

  function automatic logic [7:0] round_clamp(input logic signed [18:0] sum);
    logic signed [18:0] r;
    logic [7:0]         px;
    r = (sum + ROUND_HALF) >>> COEF_FRAC;
    if (r < 19'sd0) begin
      px = 8'd0;
    end else if (r > 19'sd255) begin
      px = 8'd255;
    end else begin
      px = r[7:0];
    end
    return px;
  endfunction

  logic               s1_v_r, s2_v_r, s3_v_r;
  logic [95:0]        s1_taps_r;
  logic [1:0]         s1_phase_r;
  logic               s1_eol_r, s1_eof_r, s1_sof_r;
  logic signed [17:0] s2_lo_s [3];
  logic signed [17:0] s2_hi_s [3];
  logic signed [17:0] s2_lo_r [3];
  logic signed [17:0] s2_hi_r [3];
  logic               s2_eol_r, s2_eof_r, s2_sof_r;
  logic [23:0]        s3_data_s;
  logic [23:0]        s3_data_r;
  logic               s3_eol_r, s3_eof_r, s3_sof_r;
  logic [1:0]         phase_r;
  logic               sof_pending_r, len_err_r;
  logic               ready1_s, ready2_s, ready3_s, accept_s;

  // Stage-advance chain: a stage loads when empty or when its successor moves
  always_comb begin
    ready3_s = ~s3_v_r | m_axis.tready;
    ready2_s = ~s2_v_r | ready3_s;
    ready1_s = ~s1_v_r | ready2_s;
    accept_s = s_axis.tvalid & ready1_s;
  end

  // Line phase, frame-start flag and sticky line-length error
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      phase_r       <= 2'd0;
      sof_pending_r <= 1'b1;
      len_err_r     <= 1'b0;
    end else if (accept_s) begin
      if (s_axis.tlast) begin
        phase_r <= 2'd0;
        if (phase_r != LAST_PHASE) begin
          len_err_r <= 1'b1;
        end
      end else begin
        phase_r <= phase_r + 2'd1;
      end
      sof_pending_r <= s_axis.eof;
    end
  end

  // S1: capture taps, phase and sidebands
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_v_r     <= 1'b0;
      s1_taps_r  <= 96'd0;
      s1_phase_r <= 2'd0;
      s1_eol_r   <= 1'b0;
      s1_eof_r   <= 1'b0;
      s1_sof_r   <= 1'b0;
    end else if (ready1_s) begin
      s1_v_r <= accept_s;
      if (accept_s) begin
        s1_taps_r  <= s_axis.tdata;
        s1_phase_r <= phase_r;
        s1_eol_r   <= s_axis.tlast;
        s1_eof_r   <= s_axis.eof;
        s1_sof_r   <= sof_pending_r;
      end
    end
  end

  // S2 datapath: per-channel products folded into (p0,p1) and (p2,p3) partials
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      s2_lo_s[ch] = 18'(prod(s1_taps_r[8*ch +: 8],      coef(s1_phase_r, 2'd0)))
                  + 18'(prod(s1_taps_r[24 + 8*ch +: 8], coef(s1_phase_r, 2'd1)));
      s2_hi_s[ch] = 18'(prod(s1_taps_r[48 + 8*ch +: 8], coef(s1_phase_r, 2'd2)))
                  + 18'(prod(s1_taps_r[72 + 8*ch +: 8], coef(s1_phase_r, 2'd3)));
    end
  end

  // S2 register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s2_v_r   <= 1'b0;
      s2_eol_r <= 1'b0;
      s2_eof_r <= 1'b0;
      s2_sof_r <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        s2_lo_r[ch] <= 18'sd0;
        s2_hi_r[ch] <= 18'sd0;
      end
    end else if (ready2_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_eol_r <= s1_eol_r;
        s2_eof_r <= s1_eof_r;
        s2_sof_r <= s1_sof_r;
        for (int ch = 0; ch < 3; ch++) begin
          s2_lo_r[ch] <= s2_lo_s[ch];
          s2_hi_r[ch] <= s2_hi_s[ch];
        end
      end
    end
  end

  // S3 datapath: final sum, round and clamp per channel
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      s3_data_s[8*ch +: 8] = round_clamp(19'(s2_lo_r[ch]) + 19'(s2_hi_r[ch]));
    end
  end

  // S3 output register: holds steady while the downstream stalls
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s3_v_r    <= 1'b0;
      s3_data_r <= 24'd0;
      s3_eol_r  <= 1'b0;
      s3_eof_r  <= 1'b0;
      s3_sof_r  <= 1'b0;
    end else if (ready3_s) begin
      s3_v_r <= s2_v_r;
      if (s2_v_r) begin
        s3_data_r <= s3_data_s;
        s3_eol_r  <= s2_eol_r;
        s3_eof_r  <= s2_eof_r;
        s3_sof_r  <= s2_sof_r;
      end
    end
  end

  assign s_axis.tready = ready1_s;
  assign m_axis.tvalid = s3_v_r;
  assign m_axis.tdata  = s3_data_r;
  assign m_axis.tlast  = s3_eol_r;
  assign m_axis.eof    = s3_eof_r;
  assign m_axis_tuser  = s3_sof_r;
  assign o_len_err     = len_err_r;
endmodule

// File: tb/tb_bicubic_tap_filter.sv
// Scoreboard bench for bicubic_tap_filter: driver pushes model results, monitor pops on
// each output handshake; randomized taps and downstream backpressure.
module tb_bicubic_tap_filter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tuser, len_err;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 1;
  bit   mon_en = 1'b1;
  bit   lat_chk = 1'b0;

  bicubic_tap_filter_if #(.DATA_W(96)) s_if ();
  bicubic_tap_filter_if #(.DATA_W(24)) m_if ();

  bicubic_tap_filter #(.COEF_FRAC(7), .LINE_PHASES(4)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .m_axis_tuser (tuser),
    .o_len_err    (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // downstream ready: 0 = stalled, 1 = always ready, other = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b0;
      1:       m_if.tready = 1'b1;
      default: m_if.tready = ($urandom_range(0, 1) == 1);
    endcase
  end

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic        sof;
    logic        eof;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int ktab [4][4] = '{'{0, 128, 0, 0}, '{-9, 111, 29, -3}, '{-8, 72, 72, -8}, '{-3, 29, 111, -9}};
  int m_phase = 0;
  bit m_sof = 1'b1;
  bit m_lenerr = 1'b0;

  function automatic logic [23:0] model_pix(input logic [95:0] d, input int ph);
    logic [23:0] r;
    int acc;
    for (int ch = 0; ch < 3; ch++) begin
      acc = 0;
      for (int t = 0; t < 4; t++) acc += ktab[ph][t] * int'(d[24*t + 8*ch +: 8]);
      acc = (acc + 64) >>> 7;
      if (acc < 0) acc = 0;
      if (acc > 255) acc = 255;
      r[8*ch +: 8] = acc[7:0];
    end
    return r;
  endfunction

  function automatic logic [95:0] mk(input logic [7:0] p0, input logic [7:0] p1,
                                     input logic [7:0] p2, input logic [7:0] p3);
    return {{3{p3}}, {3{p2}}, {3{p1}}, {3{p0}}};
  endfunction

  task automatic push_expect(input logic [95:0] d, input logic eol, input logic eof);
    exp_t e;
    e.data = model_pix(d, m_phase);
    e.last = eol;
    e.sof  = m_sof;
    e.eof  = eof;
    e.cyc  = cyc;
    q.push_back(e);
    if (eol) begin
      if (m_phase != 3) m_lenerr = 1'b1;
      m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % 4;
    end
    m_sof = eof;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic send_beat(input logic [95:0] d, input logic eol, input logic eof);
    bit done = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = eol;
    s_if.eof    = eof;
    s_if.tvalid = 1'b1;
    for (int w = 0; w < 1000 && !done; w++) begin
      @(negedge clk);
      if (s_if.tready) begin
        push_expect(d, eol, eof);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (q.size() != 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    check("drain_left", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // monitor: pops on every output handshake and checks hold-while-stalled
  logic [27:0] held;
  bit          stall_r = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      stall_r = 1'b0;
    end else begin
      if (stall_r) begin
        n_cmp++;
        if ({m_if.tvalid, m_if.tdata, m_if.tlast, tuser, m_if.eof} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got %h, want %h", {m_if.tvalid, m_if.tdata, m_if.tlast, tuser, m_if.eof}, held);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got pixel %h, want no output", m_if.tdata);
        end else begin
          e = q.pop_front();
          if (m_if.tdata !== e.data || m_if.tlast !== e.last || tuser !== e.sof || m_if.eof !== e.eof) begin
            n_fail++;
            $display("FAIL pixel: got data=%h last=%b sof=%b eof=%b, want data=%h last=%b sof=%b eof=%b",
                     m_if.tdata, m_if.tlast, tuser, m_if.eof, e.data, e.last, e.sof, e.eof);
          end
          if (lat_chk) begin
            n_cmp++;
            if (cyc - e.cyc != 3) begin
              n_fail++;
              $display("FAIL latency: got %0d cycles, want 3", cyc - e.cyc);
            end
          end
        end
      end
      stall_r = m_if.tvalid && !m_if.tready;
      held    = {m_if.tvalid, m_if.tdata, m_if.tlast, tuser, m_if.eof};
    end
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 96'd0;
    s_if.tlast  = 1'b0;
    s_if.eof    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_eof", 32'(m_if.eof), 32'd0);
    check("rst_tready", 32'(s_if.tready), 32'd1);
    check("rst_len_err", 32'(len_err), 32'd0);
    @(posedge clk);
    #1;

    // flat frame, continuous flow, latency checked on every pixel
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(mk(8'd100, 8'd100, 8'd100, 8'd100), (i % 4) == 3, i == 7);
    wait_drain();
    lat_chk = 1'b0;

    // ramp across phases 0..3
    for (int i = 0; i < 4; i++) send_beat(mk(8'd0, 8'd64, 8'd128, 8'd192), i == 3, 1'b0);
    // clamp corners
    send_beat(mk(8'd10, 8'd20, 8'd30, 8'd40), 1'b0, 1'b0);
    send_beat(mk(8'd255, 8'd0, 8'd0, 8'd0), 1'b0, 1'b0);
    send_beat(mk(8'd0, 8'd255, 8'd255, 8'd0), 1'b0, 1'b0);
    send_beat(mk(8'd7, 8'd7, 8'd7, 8'd7), 1'b1, 1'b0);
    send_beat(mk(8'd1, 8'd2, 8'd3, 8'd4), 1'b0, 1'b0);
    send_beat(mk(8'd0, 8'd0, 8'd255, 8'd255), 1'b0, 1'b0);
    send_beat(mk(8'd9, 8'd9, 8'd9, 8'd9), 1'b0, 1'b0);
    send_beat(mk(8'd200, 8'd100, 8'd50, 8'd25), 1'b1, 1'b0);
    wait_drain();
    check("len_err_clean", 32'(len_err), 32'(m_lenerr));

    // short line, then a full line resynchronised to phase 0
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom, $urandom}, i == 2, 1'b0);
    wait_drain();
    check("len_err_set", 32'(len_err), 32'(m_lenerr));
    for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom, $urandom}, i == 3, i == 3);
    wait_drain();
    check("len_err_sticky", 32'(len_err), 32'(m_lenerr));

    // fill the stalled pipeline, then reset with three beats in flight
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    @(negedge clk);
    check("full_tready", 32'(s_if.tready), 32'd0);
    check("full_tvalid", 32'(m_if.tvalid), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    q.delete();
    m_phase  = 0;
    m_sof    = 1'b1;
    m_lenerr = 1'b0;
    @(negedge clk);
    check("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_len_err", 32'(len_err), 32'd0);
    check("mid_rst_tready", 32'(s_if.tready), 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // two 1280-beat lines under random valid gaps and random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 2560; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_beat({$urandom, $urandom, $urandom}, (i % 1280) == 1279, i == 2559);
    end
    rdy_mode = 1;
    wait_drain();
    check("bp_len_err", 32'(len_err), 32'(m_lenerr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
